if_id_pipe: RTL and testbench
=============================

// Module: if_id_pipe
// PURPOSE
//  Parametrised IF->ID pipeline register with a valid/ready handshake, flush and back-pressure.
//  Sits between the fetch stage and the decode stage.
//  Carries PC, instruction and a branch-predicted-taken bit.
//  Inserts a NOP bubble on flush or empty, and counts bubble cycles for performance analysis.
// PARAMETERS
//  ADDR_W    32             PC width
//  INST_W    32             instruction width
//  NOP_INST  {INST_W{1'b0}} instruction presented when the stage is empty or flushed
//  CNT_W     16             bubble counter width
// PORTS
//  One clock; reset is asynchronous and active-high.
//  clk            in   1       clock, all state on posedge
//  rst            in   1       asynchronous reset, active-high
//  flush          in   1       discard all held/incoming instructions (branch redirect)
//  if_valid       in   1       IF presents an instruction
//  if_ready       out  1       stage can accept this cycle
//  if_pc          in   ADDR_W  fetch PC
//  if_inst        in   INST_W  fetched instruction
//  if_pred_taken  in   1       predictor said taken
//  id_valid       out  1       ID-side payload valid
//  id_ready       in   1       ID can consume this cycle
//  id_pc          out  ADDR_W  registered PC
//  id_inst        out  INST_W  registered instruction (NOP_INST when !id_valid)
//  id_pred_taken  out  1       registered predict bit (0 when !id_valid)
//  bubble_cnt     out  CNT_W   saturating count of cycles with id_valid==0
// BEHAVIOUR
//  - Reset (async): id_valid=0, id_pc=0, id_inst=NOP_INST, id_pred_taken=0, bubble_cnt=0, skid empty.
//  - Accept: if_valid && if_ready at the edge. Consume: id_valid && id_ready at the edge.
//  - Latency: one cycle from accept to id_valid. Payload is held stable while id_valid && !id_ready.
//  - Flush has priority over accept and consume:
//      next cycle id_valid=0, id_inst=NOP_INST, id_pred_taken=0, id_pc holds.
//      The instruction offered in the flush cycle is dropped.
//  - Simultaneous consume and accept (no flush): the new payload loads with no bubble.
//  - id_inst/id_pred_taken are forced to NOP/0 whenever id_valid=0, never stale data.
//  - bubble_cnt increments each cycle id_valid==0, saturates at all-ones, cleared only by rst.
//  - rst asserted mid-transfer: the in-flight payload is lost, no partial output.
// CONFIGURATION
//  IF_ID_SKID_EN undefined: single entry.
//    - if_ready = !id_valid || id_ready (combinational path from id_ready).
//  IF_ID_SKID_EN defined: 2-entry skid buffer; if_ready is registered, no id_ready->if_ready path.
//    - FSM states EMPTY, FULL (main valid) and SKID (main+skid valid). if_ready = (state!=SKID).
//    - EMPTY: accept -> FULL.
//    - FULL: accept&!consume -> SKID; consume&!accept -> EMPTY; accept&consume -> FULL with the new payload.
//    - SKID: consume -> FULL, skid moves to main (in order); no accept is possible.
//    - flush from any state -> EMPTY, both entries cleared.
//    - Order preserved, no loss/duplication.
// STRUCTURE
//  - Shared defines file holds RstEnable, ZeroWord, InstAddrBus, InstBus and the NOP encoding.
//  - FSM state encodings are local parameters.
//  - Sub-module if_id_skid_buf: payload storage + FSM, instantiated only under IF_ID_SKID_EN.
//  - Top level keeps flush, NOP forcing and bubble_cnt.
// TESTING
//  1) rst=1 mid-run -> all outputs at reset values immediately, without waiting for clk.
//  2) Stream pc=0x0,0x4,0x8 with id_ready=1 -> id_pc the same sequence, 1-cycle latency, bubble_cnt frozen.
//  3) id_ready=0 for 3 cycles while if_valid=1 -> payload stable.
//     - no skid: if_ready=0.
//     - skid: exactly one extra accepted, then if_ready=0.
//     - release: pcs in order.
//  4) flush with id_valid=1 and if_valid=1 (pc=0x10) -> next cycle id_valid=0, id_inst=NOP_INST; 0x10 never appears.
//  5) if_valid=0 for 2^CNT_W+5 cycles -> bubble_cnt saturates at all-ones, no wrap.
//  6) Random valid/ready/flush for 10k cycles, checked against a scoreboard -> no loss, duplication or reorder.

Source files
------------

// File: rtl/if_id_pipe_pkg.sv
// Shared IF/ID definitions: reset level, bus widths, NOP encoding and skid-buffer states.
// Used by if_id_pipe and, when IF_ID_SKID_EN is defined, by if_id_skid_buf.
package if_id_pipe_pkg;

    localparam logic        RstEnable   = 1'b1;
    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic [31:0] NopInst     = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/if_id_skid_buf.sv
// Two-entry skid buffer for the IF->ID stage; in_ready_o is registered so there is no
// combinational path from out_ready_i. Instantiated by if_id_pipe only under IF_ID_SKID_EN.
module if_id_skid_buf
    import if_id_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = InstAddrBus,
    parameter int unsigned INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_pc_i,
    input  logic [INST_W-1:0] in_inst_i,
    input  logic              in_pred_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_pc_o,
    output logic [INST_W-1:0] out_inst_o,
    output logic              out_pred_o
);

    skid_state_e       state_q;
    logic              ready_q;
    logic [ADDR_W-1:0] main_pc_q, skid_pc_q;
    logic [INST_W-1:0] main_inst_q, skid_inst_q;
    logic              main_pred_q, skid_pred_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= EMPTY;
            ready_q     <= 1'b1;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            main_pred_q <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pred_q <= 1'b0;
        end else if (flush_i) begin
            // main PC is kept so id_pc holds across a redirect
            state_q     <= EMPTY;
            ready_q     <= 1'b1;
            main_inst_q <= '0;
            main_pred_q <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_pred_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_valid_i) begin
                        main_pc_q   <= in_pc_i;
                        main_inst_q <= in_inst_i;
                        main_pred_q <= in_pred_i;
                        state_q     <= FULL;
                    end
                end
                FULL: begin
                    if (in_valid_i && !out_ready_i) begin
                        skid_pc_q   <= in_pc_i;
                        skid_inst_q <= in_inst_i;
                        skid_pred_q <= in_pred_i;
                        state_q     <= SKID;
                        ready_q     <= 1'b0;
                    end else if (in_valid_i && out_ready_i) begin
                        main_pc_q   <= in_pc_i;
                        main_inst_q <= in_inst_i;
                        main_pred_q <= in_pred_i;
                    end else if (out_ready_i) begin
                        state_q <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready_i) begin
                        main_pc_q   <= skid_pc_q;
                        main_inst_q <= skid_inst_q;
                        main_pred_q <= skid_pred_q;
                        state_q     <= FULL;
                        ready_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_pc_o    = main_pc_q;
    assign out_inst_o  = main_inst_q;
    assign out_pred_o  = main_pred_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with valid/ready handshake, flush, NOP forcing and bubble counter.
// Define IF_ID_SKID_EN to use the 2-entry skid buffer (registered if_ready).
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = InstAddrBus,
    parameter int unsigned       INST_W   = InstBus,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int unsigned       CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    input  logic              if_pred_taken,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_pred_taken,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              stg_valid;
    logic [ADDR_W-1:0] stg_pc;
    logic [INST_W-1:0] stg_inst;
    logic              stg_pred;
    logic [CNT_W-1:0]  cnt_q;

`ifdef IF_ID_SKID_EN
    if_id_skid_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (if_valid),
        .in_ready_o  (if_ready),
        .in_pc_i     (if_pc),
        .in_inst_i   (if_inst),
        .in_pred_i   (if_pred_taken),
        .out_valid_o (stg_valid),
        .out_ready_i (id_ready),
        .out_pc_o    (stg_pc),
        .out_inst_o  (stg_inst),
        .out_pred_o  (stg_pred)
    );
`else
    logic              valid_q;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    logic              pred_q;

    assign if_ready = !valid_q || id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            pred_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            inst_q  <= NOP_INST;
            pred_q  <= 1'b0;
        end else if (if_valid && if_ready) begin
            valid_q <= 1'b1;
            pc_q    <= if_pc;
            inst_q  <= if_inst;
            pred_q  <= if_pred_taken;
        end else if (valid_q && id_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign stg_valid = valid_q;
    assign stg_pc    = pc_q;
    assign stg_inst  = inst_q;
    assign stg_pred  = pred_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else if (!stg_valid && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign id_valid      = stg_valid;
    assign id_pc         = stg_pc;
    assign id_inst       = stg_valid ? stg_inst : NOP_INST;
    assign id_pred_taken = stg_valid & stg_pred;
    assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed and randomised self-checking bench for if_id_pipe (both IF_ID_SKID_EN builds).
module tb_if_id_pipe;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned CW = 8;
    localparam logic [IW-1:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst, flush, if_valid, if_ready, if_pred_taken;
    logic [AW-1:0] if_pc, id_pc;
    logic [IW-1:0] if_inst, id_inst;
    logic          id_valid, id_ready, id_pred_taken;
    logic [CW-1:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
        logic          pred;
    } ent_t;
    ent_t q[$];

    if_id_pipe #(
        .ADDR_W   (AW),
        .INST_W   (IW),
        .NOP_INST (NOP),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_pred_taken (if_pred_taken),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_pred_taken (id_pred_taken),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [AW-1:0] pc);
        if_valid      = v;
        if_pc         = pc;
        if_inst       = inst_of(pc);
        if_pred_taken = pc[2];
    endtask

    initial begin
        logic          exp_ready, acc, con;
        logic [AW-1:0] pc_n;
        ent_t          e;

        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        offer(1'b0, '0);
        #1;
        chk("rst_valid", id_valid, 1'b0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, NOP);
        chk("rst_pred", id_pred_taken, 1'b0);
        chk("rst_bubble", bubble_cnt, 8'd0);
        repeat (2) tick();
        rst = 1'b0;

        // streaming with 1-cycle latency
        id_ready = 1'b1;
        offer(1'b1, 32'h0);
        #1;
        chk("s_ready", if_ready, 1'b1);
        tick();
        chk("s0_valid", id_valid, 1'b1);
        chk("s0_pc", id_pc, 32'h0);
        chk("s0_inst", id_inst, inst_of(32'h0));
        chk("s0_bubble", bubble_cnt, 8'd1);
        offer(1'b1, 32'h4);
        tick();
        chk("s4_pc", id_pc, 32'h4);
        chk("s4_pred", id_pred_taken, 1'b1);
        chk("s4_bubble", bubble_cnt, 8'd1);
        offer(1'b1, 32'h8);
        tick();
        chk("s8_pc", id_pc, 32'h8);
        chk("s8_bubble", bubble_cnt, 8'd1);
        offer(1'b0, 32'h0);
        tick();
        chk("drain_valid", id_valid, 1'b0);
        chk("drain_inst", id_inst, NOP);
        chk("drain_pred", id_pred_taken, 1'b0);
        chk("drain_bubble", bubble_cnt, 8'd1);
        tick();
        chk("bubble_inc", bubble_cnt, 8'd2);

        // back-pressure
        id_ready = 1'b0;
        offer(1'b1, 32'h20);
        tick();
        chk("bp_valid", id_valid, 1'b1);
        chk("bp_pc", id_pc, 32'h20);
`ifdef IF_ID_SKID_EN
        offer(1'b1, 32'h24);
        #1;
        chk("bp_skid_ready", if_ready, 1'b1);
        tick();
        chk("bp_skid_pc", id_pc, 32'h20);
        offer(1'b1, 32'h28);
        #1;
        chk("bp_full_ready", if_ready, 1'b0);
        repeat (2) begin
            tick();
            chk("bp_hold_pc", id_pc, 32'h20);
            chk("bp_hold_inst", id_inst, inst_of(32'h20));
            chk("bp_hold_ready", if_ready, 1'b0);
        end
        id_ready = 1'b1;
        tick();
        chk("rel_pc24", id_pc, 32'h24);
        chk("rel_ready", if_ready, 1'b1);
        tick();
        chk("rel_pc28", id_pc, 32'h28);
`else
        offer(1'b1, 32'h24);
        #1;
        chk("bp_ready", if_ready, 1'b0);
        repeat (3) begin
            tick();
            chk("bp_hold_pc", id_pc, 32'h20);
            chk("bp_hold_inst", id_inst, inst_of(32'h20));
            chk("bp_hold_ready", if_ready, 1'b0);
        end
        id_ready = 1'b1;
        #1;
        chk("rel_ready", if_ready, 1'b1);
        tick();
        chk("rel_pc24", id_pc, 32'h24);
`endif
        offer(1'b0, 32'h0);
        tick();
        chk("rel_empty", id_valid, 1'b0);

        // flush drops held and incoming instructions
        id_ready = 1'b0;
        offer(1'b1, 32'h30);
        tick();
        chk("fl_pre_valid", id_valid, 1'b1);
        offer(1'b1, 32'h10);
        flush = 1'b1;
        id_ready = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_valid", id_valid, 1'b0);
        chk("fl_inst", id_inst, NOP);
        chk("fl_pred", id_pred_taken, 1'b0);
        chk("fl_pc_hold", id_pc, 32'h30);
        offer(1'b0, 32'h0);
        tick();
        chk("fl_no_0x10", id_valid, 1'b0);

        // asynchronous reset mid-transfer
        id_ready = 1'b0;
        offer(1'b1, 32'h44);
        tick();
        chk("ar_pre_valid", id_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", id_valid, 1'b0);
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_inst", id_inst, NOP);
        chk("ar_pred", id_pred_taken, 1'b0);
        chk("ar_bubble", bubble_cnt, 8'd0);
        offer(1'b0, 32'h0);
        tick();
        rst = 1'b0;

        // bubble counter saturation: 2^CW+5 empty cycles
        repeat (254) tick();
        chk("sat_254", bubble_cnt, 8'd254);
        tick();
        chk("sat_255", bubble_cnt, 8'd255);
        repeat (6) tick();
        chk("sat_hold", bubble_cnt, 8'd255);

        // randomised traffic against a queue model
        pc_n = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            flush    = ($urandom_range(0, 19) == 0);
            id_ready = ($urandom_range(0, 9) < 6);
            offer(($urandom_range(0, 9) < 7), pc_n);
            if_pred_taken = $urandom_range(0, 1) == 1;
            #1;
`ifdef IF_ID_SKID_EN
            exp_ready = (q.size() < 2);
`else
            exp_ready = (q.size() == 0) || id_ready;
`endif
            chk("rnd_ready", if_ready, exp_ready);
            chk("rnd_valid", id_valid, q.size() != 0);
            if (q.size() == 0) begin
                chk("rnd_nop_inst", id_inst, NOP);
                chk("rnd_nop_pred", id_pred_taken, 1'b0);
            end else begin
                chk("rnd_pc", id_pc, q[0].pc);
                chk("rnd_inst", id_inst, q[0].inst);
                chk("rnd_pred", id_pred_taken, q[0].pred);
            end
            acc = if_valid && exp_ready;
            con = (q.size() != 0) && id_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (con) void'(q.pop_front());
                if (acc) begin
                    e.pc   = if_pc;
                    e.inst = if_inst;
                    e.pred = if_pred_taken;
                    q.push_back(e);
                end
            end
            pc_n = pc_n + 32'd4;
            tick();
        end
        offer(1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("end_empty", id_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
